// File: rtl/branch_cmp_pipe.sv
// Registered branch-condition unit for the ID/EX boundary: evaluates the
// condition selected by op, buffers one decision and keeps saturating stats.
module branch_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_br,
  output logic             out_link,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_EQ   = 4'b0001;
  localparam logic [3:0] OP_GTZ  = 4'b0010;
  localparam logic [3:0] OP_GEZ  = 4'b0011;
  localparam logic [3:0] OP_GEZL = 4'b0100;
  localparam logic [3:0] OP_LEZ  = 4'b0101;
  localparam logic [3:0] OP_LTZ  = 4'b0110;
  localparam logic [3:0] OP_NE   = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1000;
  localparam logic [3:0] OP_LTU  = 4'b1001;
  localparam logic [3:0] OP_GE   = 4'b1010;
  localparam logic [3:0] OP_GEU  = 4'b1011;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic a_neg, a_zero, a_eq_b, a_lt_s, a_lt_u;
  logic cond_br, cond_link, cond_illegal;
  logic accept, consume;

  // Handshake: a transfer happens on either side only when valid and ready
  // are both high at a rising edge. in_ready is combinational and never looks
  // at in_valid; out_* are held stable while out_valid=1 and out_ready=0.
  assign in_ready = reset & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready & ~flush;

  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);
  assign a_eq_b = (A == B);
  assign a_lt_s = ($signed(A) < $signed(B));
  assign a_lt_u = (A < B);

  always_comb begin
    cond_br      = 1'b0;
    cond_link    = 1'b0;
    cond_illegal = 1'b0;
    case (Op)
      OP_NONE: cond_br = 1'b0;
      OP_EQ:   cond_br = a_eq_b;
      OP_GTZ:  cond_br = ~a_neg & ~a_zero;
      OP_GEZ:  cond_br = ~a_neg;
      OP_GEZL: begin
        cond_br   = ~a_neg;
        cond_link = 1'b1;
      end
      OP_LEZ:  cond_br = a_neg | a_zero;
      OP_LTZ:  cond_br = a_neg;
      OP_NE:   cond_br = ~a_eq_b;
      OP_LT:   cond_br = a_lt_s;
      OP_LTU:  cond_br = a_lt_u;
      OP_GE:   cond_br = ~a_lt_s;
      OP_GEU:  cond_br = ~a_lt_u;
      default: cond_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_br      <= 1'b0;
      out_link    <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      taken_cnt   <= '0;
      total_cnt   <= '0;
    end else if (flush) begin
      // Flush discards both the buffered and any incoming decision uncounted.
      out_valid <= 1'b0;
    end else begin
      if (consume) begin
        if (total_cnt != CNT_MAX) total_cnt <= total_cnt + CNT_ONE;
        if (out_br && taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_ONE;
      end
      if (accept) begin
        out_valid   <= 1'b1;
        out_br      <= cond_br;
        out_link    <= cond_link;
        out_illegal <= cond_illegal;
        out_tag     <= in_tag;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed bench for branch_cmp_pipe: a 16-bit-counter instance and a 2-bit
// counter instance share stimulus; a queue scoreboard predicts every decision.
module tb_branch_cmp_pipe;

  localparam int W = 32;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         reset, in_valid, flush, out_ready;
  logic [W-1:0] A, B;
  logic [3:0]   Op;
  logic [T-1:0] in_tag;

  logic         in_ready, out_valid, out_br, out_link, out_illegal;
  logic [T-1:0] out_tag;
  logic [15:0]  taken_cnt, total_cnt;

  logic         s_in_ready, s_out_valid, s_out_br, s_out_link, s_out_illegal;
  logic [T-1:0] s_out_tag;
  logic [1:0]   s_taken_cnt, s_total_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m_taken = 0;
  int m_total = 0;
  logic [T+2:0] exp_q[$];  // {illegal, link, br, tag}

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(W), .TAG_W(T), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_br(out_br),
    .out_link(out_link), .out_illegal(out_illegal), .out_tag(out_tag),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  branch_cmp_pipe #(.WIDTH(W), .TAG_W(T), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .A(A), .B(B), .Op(Op), .in_tag(in_tag), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_br(s_out_br),
    .out_link(s_out_link), .out_illegal(s_out_illegal), .out_tag(s_out_tag),
    .taken_cnt(s_taken_cnt), .total_cnt(s_total_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference condition; signed order is obtained by flipping sign bits
  // and comparing unsigned.
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] op);
    logic [W-1:0] msb;
    logic neg, zero, slt, ult;
    msb  = {1'b1, {(W-1){1'b0}}};
    neg  = a[W-1];
    zero = (a == 0);
    slt  = ((a ^ msb) < (b ^ msb));
    ult  = (a < b);
    case (op)
      4'd0:  return 3'b000;
      4'd1:  return {2'b00, a == b};
      4'd2:  return {2'b00, !neg && !zero};
      4'd3:  return {2'b00, !neg};
      4'd4:  return {2'b01, !neg};
      4'd5:  return {2'b00, neg || zero};
      4'd6:  return {2'b00, neg};
      4'd7:  return {2'b00, a != b};
      4'd8:  return {2'b00, slt};
      4'd9:  return {2'b00, ult};
      4'd10: return {2'b00, !slt};
      4'd11: return {2'b00, !ult};
      default: return 3'b100;
    endcase
  endfunction

  // One clock: pre-edge checks and model update, edge, post-edge checks.
  task automatic cycle();
    logic exp_rdy, acc, cons;
    logic [T+2:0] e;
    #1;
    exp_rdy = reset && (exp_q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("sat_in_ready", s_in_ready, exp_rdy);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_br", out_br, e[T]);
      chk("out_link", out_link, e[T+1]);
      chk("out_illegal", out_illegal, e[T+2]);
      chk("out_tag", out_tag, e[T-1:0]);
      chk("sat_out_br", s_out_br, e[T]);
    end
    acc  = in_valid && exp_rdy;
    cons = (exp_q.size() != 0) && out_ready;
    if (!reset) begin
      exp_q.delete();
      m_taken = 0;
      m_total = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (cons) begin
        e = exp_q.pop_front();
        m_total++;
        if (e[T]) m_taken++;
      end
      if (acc) exp_q.push_back({model(A, B, Op), in_tag});
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("sat_out_valid", s_out_valid, exp_q.size() != 0);
    chk("total_cnt", total_cnt, (m_total > 65535) ? 65535 : m_total);
    chk("taken_cnt", taken_cnt, (m_taken > 65535) ? 65535 : m_taken);
    chk("sat_total_cnt", s_total_cnt, (m_total > 3) ? 3 : m_total);
    chk("sat_taken_cnt", s_taken_cnt, (m_taken > 3) ? 3 : m_taken);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input logic [T-1:0] tag);
    in_valid = 1'b1;
    A = a;
    B = b;
    Op = op;
    in_tag = tag;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_br"}, out_br, 0);
    chk({tag, "_link"}, out_link, 0);
    chk({tag, "_illegal"}, out_illegal, 0);
    chk({tag, "_tag"}, out_tag, 0);
    chk({tag, "_taken"}, taken_cnt, 0);
    chk({tag, "_total"}, total_cnt, 0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Op = '0; in_tag = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    check_cleared("reset");
    reset = 1'b1;

    // Equality, consumed next cycle
    push(32'h0000_1234, 32'h0000_1234, 4'b0001, 5'd1);
    chk("eq_br", out_br, 1);
    cycle(); cycle();
    chk("eq_total", total_cnt, 1);
    chk("eq_taken", taken_cnt, 1);

    // Signed vs unsigned, back to back
    push(32'hFFFF_FFFF, 32'h0000_0001, 4'b1000, 5'd2);
    push(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 5'd3);
    push(32'hFFFF_FFFF, 32'h0000_0001, 4'b1010, 5'd4);
    push(32'hFFFF_FFFF, 32'h0000_0001, 4'b1011, 5'd5);
    push(32'h8000_0000, 32'h7FFF_FFFF, 4'b1000, 5'd6);
    chk("minneg_lt_maxpos", out_br, 1);
    cycle();

    // Stall with tag 1A; a pending input must not be accepted
    push(32'h5, 32'h5, 4'b0001, 5'h1A);
    out_ready = 1'b0;
    in_valid = 1'b1; Op = 4'b0111; in_tag = 5'h03;
    repeat (3) cycle();
    chk("stall_tag", out_tag, 5'h1A);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Linking branch and reserved op
    push(32'hFFFF_FFF0, 32'h0, 4'b0100, 5'd7);
    chk("link_br", out_br, 0);
    chk("link_link", out_link, 1);
    push(32'h0, 32'h0, 4'b1101, 5'd8);
    chk("illegal", out_illegal, 1);
    chk("illegal_br", out_br, 0);
    cycle();

    // Random ops and backpressure
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      A = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      B = ($urandom_range(0, 3) == 0) ? A : $urandom;
      Op = 4'($urandom_range(0, 15));
      in_tag = 5'($urandom_range(0, 31));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Flush against simultaneous consume and accept
    push(32'h1, 32'h1, 4'b0001, 5'd9);
    flush = 1'b1;
    in_valid = 1'b1; Op = 4'b0001; in_tag = 5'd10;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    cycle();

    // Reset in the middle of a stall
    push(32'h2, 32'h3, 4'b0111, 5'h15);
    out_ready = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    check_cleared("midstall");
    reset = 1'b1; out_ready = 1'b1;

    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) push(32'h9, 32'h9, 4'b0001, 5'(i));
    cycle();
    chk("sat_taken3", s_taken_cnt, 3);
    chk("sat_total3", s_total_cnt, 3);
    chk("wide_total5", total_cnt, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised, registered branch-condition unit for the ID/EX boundary of the pipelined MIPS core.
- Evaluates the branch condition selected by Op on A and B. Extends the original 3-bit opcode set with signed and unsigned less-than / greater-or-equal compares and a link indication.
- Registers the decision into a one-entry output buffer with valid/ready handshake, flush and saturating taken/total statistics counters.

Parameters:
- WIDTH, 32, operand width in bits (≥2).
- TAG_W, 5, width of the sideband tag (e.g. destination/PC index) carried with each decision.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- in_valid  input  1  A/B/Op/in_tag valid this cycle.
- in_ready  output  1  unit can accept an input this cycle.
- A  input  WIDTH  first operand, two's complement.
- B  input  WIDTH  second operand.
- Op  input  4  condition select (encoding below).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- flush  input  1  kill buffered and incoming decision.
- out_valid  output  1  buffered decision valid.
- out_ready  input  1  consumer accepts decision.
- out_br  output  1  branch taken.
- out_link  output  1  op is a linking branch (write $ra regardless of out_br).
- out_illegal  output  1  Op was reserved.
- out_tag  output  TAG_W  tag of buffered decision.
- taken_cnt  output  CNT_W  count of consumed decisions with out_br=1.
- total_cnt  output  CNT_W  count of all consumed decisions.

Behaviour:
- Op encoding:
  - 0000 none → br=0.
  - 0001 A==B.
  - 0010 A>0 (sign=0 and A≠0).
  - 0011 A≥0.
  - 0100 A≥0 with link=1.
  - 0101 A≤0 (sign=1 or A==0).
  - 0110 A<0.
  - 0111 A≠B.
  - 1000 A<B signed.
  - 1001 A<B unsigned.
  - 1010 A≥B signed.
  - 1011 A≥B unsigned.
  - 1100–1111 reserved → br=0, link=0, illegal=1.
- Sign is bit WIDTH-1. Signed compares use full-width two's complement; no overflow artefacts (e.g. most-negative < most-positive).
- in_ready = reset & (!out_valid | out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept with flush=0: condition result, link, illegal and in_tag are registered; out_valid=1 next cycle. Latency exactly 1 cycle.
- Hold: while out_valid=1 and out_ready=0, all out_* remain stable and in_ready=0.
- Back-to-back: consume and accept in the same cycle replaces the buffer. out_valid stays 1 and throughput is 1 per cycle.
- Consume = out_valid & out_ready & !flush.
  - total_cnt+1 on consume.
  - taken_cnt+1 if out_br also 1.
  - Both saturate at 2^CNT_W−1; no wrap.
- flush=1: next cycle out_valid=0. Any input accepted that cycle is discarded. The buffered decision is not counted, even if out_ready=1. Counters are otherwise held. Flush takes priority over accept and consume.
- Reset (reset=0): next edge clears out_valid, out_br, out_link, out_illegal, out_tag, taken_cnt and total_cnt to 0. in_ready=0 while reset=0. Reset mid-hold drops the buffered decision. Reset overrides flush and handshakes.
- out_br/out_link/out_illegal/out_tag are don't-care-stable when out_valid=0; the implementation holds last values.

Test Plan:
- Reset, then push Op=0001 with A=B=0x0000_1234 and out_ready=1 → next cycle out_valid=1, out_br=1; total_cnt=1, taken_cnt=1 one cycle later.
- Signed vs unsigned: A=0xFFFF_FFFF, B=0x0000_0001. Op=1000 → br=1; Op=1001 → br=0; Op=1010 → br=0; Op=1011 → br=1. A=0x8000_0000, B=0x7FFF_FFFF, Op=1000 → br=1.
- Stall: out_ready=0 for 3 cycles after a decision with in_tag=5'h1A → in_ready=0, out_tag=5'h1A held stable; counters unchanged until out_ready=1.
- Op=0100 with A=0xFFFF_FFF0 → out_br=0, out_link=1. Op=1101 → out_illegal=1, out_br=0.
- Flush with out_valid=1, out_ready=1 and a simultaneous in_valid accept → next cycle out_valid=0, total_cnt unchanged. Reset asserted mid-stall → all outputs 0.
- CNT_W=2: consume 5 taken decisions → taken_cnt=total_cnt=3, saturated, with no wrap.
